// File: rtl/run_controller.sv
// run_controller: run-control unit for the processor core.
// Debounces the continue / single-step / soft-reset buttons, compares the PC
// against NUM_BP address breakpoints, and sequences RESET/RUN/HALTED/STEP.
// Ports:
//   clock, reset      core clock, asynchronous active-low reset
//   cont_n, step_n,   raw active-low buttons (continue, single-step,
//   sreset_n          soft reset)
//   halt_req          halt decoded from the current instruction
//   pc                current instruction address
//   bp_addr, bp_en    breakpoint slot addresses (slot i at [i*PC_WIDTH +:
//                     PC_WIDTH]) and per-slot enables
//   pc_enable         PC may advance / instruction retires (combinational)
//   core_reset        synchronous reset to the PC, high only in RESET
//   state             0=RESET 1=RUN 2=HALTED 3=STEP
//   retired           saturating retired-instruction count
//   bp_hit, bp_index  last halt came from a breakpoint, lowest matching slot
module run_controller #(
  parameter int PC_WIDTH        = 32,
  parameter int NUM_BP          = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_CYCLES    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cont_n,
  input  logic                       step_n,
  input  logic                       sreset_n,
  input  logic                       halt_req,
  input  logic [PC_WIDTH-1:0]        pc,
  input  logic [NUM_BP*PC_WIDTH-1:0] bp_addr,
  input  logic [NUM_BP-1:0]          bp_en,
  output logic                       pc_enable,
  output logic                       core_reset,
  output logic [1:0]                 state,
  output logic [31:0]                retired,
  output logic                       bp_hit,
  output logic [2:0]                 bp_index
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } runState_e;

  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCW-1:0] DB_ONE  = DCW'(1);
  localparam logic [DCW-1:0] DB_ZERO = DCW'(0);
  localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CYCLES - 1);
  localparam logic [RCW-1:0] RC_ONE  = RCW'(1);
  localparam logic [RCW-1:0] RC_ZERO = RCW'(0);
  localparam logic [31:0]    RET_MAX = 32'hFFFF_FFFF;

  // Button index: 0=continue, 1=step, 2=soft reset. Level 1 means released.
  logic [2:0]          rawBtn_s;
  logic [2:0]          sync1_r, sync2_r;
  logic [2:0]          acc_r, accNext_s;
  logic [2:0][DCW-1:0] dbCnt_r, dbCntNext_s;
  logic [2:0]          press_r, pressNext_s;

  runState_e           state_r, stateNext_s;
  logic                skip_r, skipNext_s;
  logic [RCW-1:0]      rstCnt_r, rstCntNext_s;
  logic                bpHit_r, bpHitNext_s;
  logic [2:0]          bpIdx_r, bpIdxNext_s;
  logic [31:0]         retired_r, retiredNext_s;
  logic                coreReset_r;
  logic                pcEnable_s;
  logic [NUM_BP-1:0]   slotHit_s;
  logic                bpMatch_s;
  logic [2:0]          bpIdx_s;

  assign rawBtn_s = {sreset_n, step_n, cont_n};

  // Debouncer next-state: a differing level must persist DEBOUNCE_CYCLES samples.
  always_comb begin
    accNext_s   = acc_r;
    dbCntNext_s = dbCnt_r;
    for (int b = 0; b < 3; b++) begin
      if (sync2_r[b] != acc_r[b]) begin
        if (dbCnt_r[b] == DB_LAST) begin
          accNext_s[b]   = sync2_r[b];
          dbCntNext_s[b] = DB_ZERO;
        end else begin
          dbCntNext_s[b] = dbCnt_r[b] + DB_ONE;
        end
      end else begin
        dbCntNext_s[b] = DB_ZERO;
      end
    end
    // Only the released->pressed edge of the accepted level makes a pulse.
    pressNext_s = acc_r & ~accNext_s;
  end

  // Button synchronisers, debouncers and registered press pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
      acc_r   <= 3'b111;
      dbCnt_r <= {3{DB_ZERO}};
      press_r <= 3'b000;
    end else begin
      sync1_r <= rawBtn_s;
      sync2_r <= sync1_r;
      acc_r   <= accNext_s;
      dbCnt_r <= dbCntNext_s;
      press_r <= pressNext_s;
    end
  end

  // Breakpoint compare; the descending scan leaves the lowest matching slot.
  always_comb begin
    bpIdx_s = 3'd0;
    for (int i = 0; i < NUM_BP; i++) begin
      slotHit_s[i] = bp_en[i] && (pc == bp_addr[i*PC_WIDTH +: PC_WIDTH]);
    end
    bpMatch_s = |slotHit_s;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      bpIdx_s = slotHit_s[i] ? 3'(i) : bpIdx_s;
    end
  end

  // PC enable: skip lets the halting instruction retire once after continue.
  always_comb begin
    case (state_r)
      ST_RUN:  pcEnable_s = skip_r | ~(halt_req | bpMatch_s);
      ST_STEP: pcEnable_s = 1'b1;
      default: pcEnable_s = 1'b0;
    endcase
  end

  // Run-control next state; a soft-reset press overrides every transition.
  always_comb begin
    stateNext_s  = state_r;
    skipNext_s   = skip_r;
    rstCntNext_s = RC_ZERO;
    bpHitNext_s  = bpHit_r;
    bpIdxNext_s  = bpIdx_r;
    if (press_r[2]) begin
      stateNext_s = ST_RESET;
      skipNext_s  = 1'b0;
    end else begin
      case (state_r)
        ST_RESET: begin
          skipNext_s = 1'b0;
          if (rstCnt_r == RC_LAST) begin
            stateNext_s = ST_RUN;
          end else begin
            rstCntNext_s = rstCnt_r + RC_ONE;
          end
        end
        ST_RUN: begin
          skipNext_s = 1'b0;
          if (!skip_r && (halt_req || bpMatch_s)) begin
            stateNext_s = ST_HALTED;
            bpHitNext_s = bpMatch_s;
            bpIdxNext_s = bpIdx_s;
          end else begin
            stateNext_s = ST_RUN;
          end
        end
        ST_HALTED: begin
          if (press_r[1]) begin
            stateNext_s = ST_STEP;
            bpHitNext_s = 1'b0;
          end else if (press_r[0]) begin
            stateNext_s = ST_RUN;
            skipNext_s  = 1'b1;
            bpHitNext_s = 1'b0;
          end else begin
            stateNext_s = ST_HALTED;
          end
        end
        ST_STEP: begin
          stateNext_s = ST_HALTED;
          bpHitNext_s = 1'b0;
        end
        default: stateNext_s = ST_RESET;
      endcase
    end
    // Counter and hit flag read zero for the whole time the core sits in RESET.
    if (stateNext_s == ST_RESET) begin
      bpHitNext_s   = 1'b0;
      retiredNext_s = 32'd0;
    end else if (pcEnable_s && (retired_r != RET_MAX)) begin
      retiredNext_s = retired_r + 32'd1;
    end else begin
      retiredNext_s = retired_r;
    end
  end

  // Run-control state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_RESET;
      skip_r      <= 1'b0;
      rstCnt_r    <= RC_ZERO;
      bpHit_r     <= 1'b0;
      bpIdx_r     <= 3'd0;
      retired_r   <= 32'd0;
      coreReset_r <= 1'b1;
    end else begin
      state_r     <= stateNext_s;
      skip_r      <= skipNext_s;
      rstCnt_r    <= rstCntNext_s;
      bpHit_r     <= bpHitNext_s;
      bpIdx_r     <= bpIdxNext_s;
      retired_r   <= retiredNext_s;
      coreReset_r <= (stateNext_s == ST_RESET);
    end
  end

  assign pc_enable  = pcEnable_s;
  assign core_reset = coreReset_r;
  assign state      = state_r;
  assign retired    = retired_r;
  assign bp_hit     = bpHit_r;
  assign bp_index   = bpIdx_r;

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed self-checking bench for run_controller with
// default parameters (PC_WIDTH=32, NUM_BP=2, DEBOUNCE_CYCLES=4, RESET_CYCLES=2).
// A vector table covers halt/breakpoint decisions from RUN; hand-written
// sequences cover buttons, stepping, soft reset, saturation and async reset.
module tb_run_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        cont_n, step_n, sreset_n, halt_req;
  logic [31:0] pc;
  logic [63:0] bp_addr;
  logic [1:0]  bp_en;
  logic        pc_enable, core_reset, bp_hit;
  logic [1:0]  state;
  logic [31:0] retired;
  logic [2:0]  bp_index;

  int checks = 0;
  int errors = 0;

  run_controller dut (
    .clock(clock), .reset(reset), .cont_n(cont_n), .step_n(step_n),
    .sreset_n(sreset_n), .halt_req(halt_req), .pc(pc), .bp_addr(bp_addr),
    .bp_en(bp_en), .pc_enable(pc_enable), .core_reset(core_reset),
    .state(state), .retired(retired), .bp_hit(bp_hit), .bp_index(bp_index)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        halt;
    logic [31:0] pcv;
    logic [31:0] bp0;
    logic [31:0] bp1;
    logic [1:0]  en;
    logic        expPcEn;
    logic [1:0]  expState;
    logic        expHit;
    logic [2:0]  expIdx;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // From HALTED: clear halt sources, press continue until RUN, then release.
  task automatic resume();
    int seen;
    seen = 0;
    halt_req = 1'b0;
    bp_en = 2'b00;
    cont_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state == 2'd1) begin
        seen = 1;
        break;
      end
    end
    chk("resume_reached_run", seen, 1);
    chk("resume_bp_hit", bp_hit, 0);
    cont_n = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    int pcEnCnt, stepCnt, runCnt, rstCnt, crCnt, firstStop, seen;
    logic [31:0] retAtReset;

    //             halt pc     bp0    bp1    en     pcEn st    hit idx
    tbl[0] = '{1'b0, 32'd3,   32'd100, 32'd12, 2'b11, 1'b1, 2'd1, 1'b0, 3'd0};
    tbl[1] = '{1'b0, 32'd12,  32'd100, 32'd12, 2'b10, 1'b0, 2'd2, 1'b1, 3'd1};
    tbl[2] = '{1'b1, 32'd5,   32'd100, 32'd12, 2'b00, 1'b0, 2'd2, 1'b0, 3'd0};
    tbl[3] = '{1'b0, 32'd12,  32'd100, 32'd12, 2'b00, 1'b1, 2'd1, 1'b0, 3'd0};
    tbl[4] = '{1'b0, 32'd100, 32'd100, 32'd12, 2'b01, 1'b0, 2'd2, 1'b1, 3'd0};
    tbl[5] = '{1'b0, 32'd100, 32'd100, 32'd12, 2'b10, 1'b1, 2'd1, 1'b0, 3'd0};
    tbl[6] = '{1'b1, 32'd12,  32'd100, 32'd12, 2'b10, 1'b0, 2'd2, 1'b1, 3'd1};
    tbl[7] = '{1'b0, 32'd7,   32'd7,   32'd7,  2'b11, 1'b0, 2'd2, 1'b1, 3'd0};
    tbl[8] = '{1'b0, 32'd7,   32'd7,   32'd7,  2'b10, 1'b0, 2'd2, 1'b1, 3'd1};

    reset = 1'b1; cont_n = 1'b1; step_n = 1'b1; sreset_n = 1'b1;
    halt_req = 1'b0; pc = 32'd0; bp_addr = 64'd0; bp_en = 2'b00;
    #2 reset = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_pc_enable", pc_enable, 0);
    chk("rst_retired", retired, 0);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_bp_index", bp_index, 0);

    // Reset release: two RESET cycles, then RUN and counting.
    tick();
    reset = 1'b1;
    tick();
    chk("start_state_c1", state, 0);
    chk("start_core_reset_c1", core_reset, 1);
    tick();
    chk("start_state_run", state, 1);
    chk("start_core_reset_off", core_reset, 0);
    chk("start_pc_enable", pc_enable, 1);
    repeat (10) tick();
    chk("start_retired10", retired, 10);

    // Halt then continue with halt_req held: exactly one retiring cycle.
    halt_req = 1'b1; pc = 32'd5;
    #1;
    chk("halt_pc_enable_same_cycle", pc_enable, 0);
    tick();
    chk("halt_state", state, 2);
    chk("halt_bp_hit", bp_hit, 0);
    pcEnCnt = 0;
    cont_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) cont_n = 1'b1;
      tick();
      if (pc_enable) pcEnCnt++;
    end
    chk("cont_pc_enable_cycles", pcEnCnt, 1);
    chk("cont_rehalt_state", state, 2);
    chk("cont_retired", retired, 11);

    // Single step while holding step_n for 50 cycles.
    pcEnCnt = 0; stepCnt = 0;
    step_n = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 50) step_n = 1'b1;
      tick();
      if (pc_enable) pcEnCnt++;
      if (state == 2'd3) stepCnt++;
    end
    chk("step_pc_enable_cycles", pcEnCnt, 1);
    chk("step_state_cycles", stepCnt, 1);
    chk("step_back_halted", state, 2);
    chk("step_retired", retired, 12);

    // Step and continue together: step wins.
    stepCnt = 0; runCnt = 0;
    step_n = 1'b0; cont_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) begin
        step_n = 1'b1; cont_n = 1'b1;
      end
      tick();
      if (state == 2'd3) stepCnt++;
      if (state == 2'd1) runCnt++;
    end
    chk("prio_step_taken", stepCnt, 1);
    chk("prio_no_run", runCnt, 0);
    chk("prio_state", state, 2);
    chk("prio_retired", retired, 13);

    resume();

    // Vector table, each applied for one cycle from RUN.
    for (int v = 0; v < 9; v++) begin
      halt_req = tbl[v].halt; pc = tbl[v].pcv;
      bp_addr = {tbl[v].bp1, tbl[v].bp0}; bp_en = tbl[v].en;
      #1;
      chk($sformatf("vec%0d_pc_enable", v), pc_enable, tbl[v].expPcEn);
      tick();
      chk($sformatf("vec%0d_state", v), state, tbl[v].expState);
      if (tbl[v].expState == 2'd2) begin
        chk($sformatf("vec%0d_bp_hit", v), bp_hit, tbl[v].expHit);
        chk($sformatf("vec%0d_bp_index", v), bp_index, tbl[v].expIdx);
        resume();
      end
    end

    // PC sweep 0..12 with slot 1 at 12 enabled.
    bp_addr = {32'd12, 32'd200}; bp_en = 2'b10; halt_req = 1'b0;
    firstStop = -1;
    for (int k = 0; k <= 12; k++) begin
      pc = k;
      #1;
      if (!pc_enable && firstStop < 0) firstStop = k;
      tick();
    end
    chk("sweep_stop_pc", firstStop, 12);
    chk("sweep_state", state, 2);
    chk("sweep_bp_hit", bp_hit, 1);
    chk("sweep_bp_index", bp_index, 1);

    // A 3-cycle glitch on cont_n is rejected.
    runCnt = 0;
    cont_n = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) cont_n = 1'b1;
      tick();
      if (state == 2'd1) runCnt++;
    end
    chk("glitch_no_run", runCnt, 0);
    chk("glitch_state", state, 2);

    resume();

    // Same sweep with the slot disabled: no halt.
    runCnt = 0;
    for (int k = 0; k <= 12; k++) begin
      pc = k;
      #1;
      if (!pc_enable) runCnt++;
      tick();
    end
    chk("sweep_dis_stops", runCnt, 0);
    chk("sweep_dis_state", state, 1);

    // Soft reset from RUN.
    rstCnt = 0; crCnt = 0; retAtReset = 32'hDEAD_BEEF;
    sreset_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) sreset_n = 1'b1;
      tick();
      if (state == 2'd0 && rstCnt == 0) retAtReset = retired;
      if (state == 2'd0) rstCnt++;
      if (core_reset) crCnt++;
    end
    chk("sreset_reset_cycles", rstCnt, 2);
    chk("sreset_core_reset_cycles", crCnt, 2);
    chk("sreset_retired_zero", retAtReset, 0);
    chk("sreset_back_run", state, 1);

    // Saturation: preload near the top and keep retiring.
    force dut.retired_r = 32'hFFFF_FFFD;
    #1;
    release dut.retired_r;
    tick();
    chk("sat_fe", retired, 32'hFFFF_FFFE);
    tick();
    chk("sat_ff", retired, 32'hFFFF_FFFF);
    repeat (3) tick();
    chk("sat_hold_pc_enable", pc_enable, 1);
    chk("sat_hold", retired, 32'hFFFF_FFFF);

    // Breakpoint halt on slot 1, step, then async reset during STEP.
    bp_addr = {32'd40, 32'd300}; bp_en = 2'b10; pc = 32'd40;
    tick();
    chk("pre_step_state", state, 2);
    chk("pre_step_bp_index", bp_index, 1);
    seen = 0;
    step_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state == 2'd3) begin
        seen = 1;
        break;
      end
    end
    chk("reached_step", seen, 1);
    reset = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_core_reset", core_reset, 1);
    chk("arst_pc_enable", pc_enable, 0);
    chk("arst_retired", retired, 0);
    chk("arst_bp_hit", bp_hit, 0);
    chk("arst_bp_index", bp_index, 0);
    step_n = 1'b1;
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
